// File: rtl/mprj_io_sequence_monitor.sv
// Watches synchronised user GPIO for an ordered start/status/window/end
// sequence and reports PASS, or FAIL when the cycle budget runs out first.
module mprj_io_sequence_monitor #(
    parameter logic [15:0] START_WORD     = 16'hAB40,
    parameter logic [15:0] END_WORD       = 16'hAB51,
    parameter logic [3:0]  STATUS_A       = 4'hA,
    parameter logic [3:0]  STATUS_B       = 4'h5,
    parameter logic [15:0] MID0_LO        = 16'h1968,
    parameter logic [15:0] MID0_HI        = 16'h198B,
    parameter logic [15:0] MID1_LO        = 16'h1DCD,
    parameter logic [15:0] MID1_HI        = 16'h1DE8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [37:0] io_in,
    input  logic        enable,
    input  logic        clear,
    output logic [3:0]  state,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic [15:0] cap0,
    output logic [15:0] cap1,
    output logic [31:0] cycles
);
    localparam int unsigned SYNC_W = 20;
    localparam int unsigned CB_W   = 16;
    localparam int unsigned ST_W   = 4;
    localparam int unsigned CYC_W  = 32;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_WAIT_START = 4'd1,
        ST_WAIT_SA    = 4'd2,
        ST_WAIT_SB    = 4'd3,
        ST_WAIT_M0    = 4'd4,
        ST_WAIT_M1    = 4'd5,
        ST_WAIT_END   = 4'd6,
        ST_PASS       = 4'd7,
        ST_FAIL       = 4'd8
    } state_e;

    state_e            state_q, state_d;
    logic [SYNC_W-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [CYC_W-1:0]  cycles_q, cycles_d;
    logic [CB_W-1:0]   cap0_q, cap0_d, cap1_q, cap1_d;
    logic              done_q, done_d, pass_q, pass_d, fail_q, fail_d;

    logic [CB_W-1:0]   cb;
    logic [ST_W-1:0]   st;
    logic              active, stay_active;

    // io_in[37:36] and io_in[15:0] carry nothing this block looks at.
    logic unused_io;
    assign unused_io = ^{io_in[37:36], io_in[15:0]};

    assign cb = sync2_q[CB_W-1:0];
    assign st = sync2_q[SYNC_W-1:CB_W];

    always_comb begin
        sync1_d     = io_in[35:16];
        sync2_d     = sync1_q;
        state_d     = state_q;
        cycles_d    = cycles_q;
        cap0_d      = cap0_q;
        cap1_d      = cap1_q;
        active      = (state_q >= ST_WAIT_START) && (state_q <= ST_WAIT_END);
        stay_active = 1'b0;

        if (clear) begin
            state_d  = ST_IDLE;
            cycles_d = '0;
            cap0_d   = '0;
            cap1_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_d  = ST_WAIT_START;
                        cycles_d = '0;
                    end
                end
                ST_WAIT_START: if (cb == START_WORD) state_d = ST_WAIT_SA;
                ST_WAIT_SA:    if (st == STATUS_A) state_d = ST_WAIT_SB;
                ST_WAIT_SB:    if (st == STATUS_B) state_d = ST_WAIT_M0;
                ST_WAIT_M0: begin
                    if (cb >= MID0_LO && cb <= MID0_HI) begin
                        state_d = ST_WAIT_M1;
                        cap0_d  = cb;
                    end
                end
                ST_WAIT_M1: begin
                    if (cb >= MID1_LO && cb <= MID1_HI) begin
                        state_d = ST_WAIT_END;
                        cap1_d  = cb;
                    end
                end
                ST_WAIT_END:   if (cb == END_WORD) state_d = ST_PASS;
                ST_PASS, ST_FAIL: ;
                default:       state_d = ST_IDLE;
            endcase

            // Budget exhausted: a simultaneous end match still wins, and no capture lands.
            if (active && state_d != ST_PASS && cycles_q == CYC_LAST) begin
                state_d = ST_FAIL;
                cap0_d  = cap0_q;
                cap1_d  = cap1_q;
            end

            stay_active = (state_d >= ST_WAIT_START) && (state_d <= ST_WAIT_END);
            if (active && stay_active && cycles_q != '1) begin
                cycles_d = cycles_q + CYC_W'(1);
            end
        end

        done_d = (state_d == ST_PASS) || (state_d == ST_FAIL);
        pass_d = (state_d == ST_PASS);
        fail_d = (state_d == ST_FAIL);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            sync1_q  <= '0;
            sync2_q  <= '0;
            cycles_q <= '0;
            cap0_q   <= '0;
            cap1_q   <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cycles_q <= cycles_d;
            cap0_q   <= cap0_d;
            cap1_q   <= cap1_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
        end
    end

    assign state  = state_q;
    assign done   = done_q;
    assign pass   = pass_q;
    assign fail   = fail_q;
    assign cap0   = cap0_q;
    assign cap1   = cap1_q;
    assign cycles = cycles_q;

endmodule

// File: tb/tb_mprj_io_sequence_monitor.sv
// Scoreboard bench: each scenario's expected outcome is computed by walking the
// stimulus word list, queued, and checked by a monitor when done rises.
module tb_mprj_io_sequence_monitor;
    localparam int TMO   = 200;
    localparam int SEQ_N = 210;
    localparam logic [15:0] W_START = 16'hAB40;
    localparam logic [15:0] W_END   = 16'hAB51;
    localparam logic [15:0] M0_LO   = 16'h1968;
    localparam logic [15:0] M0_HI   = 16'h198B;
    localparam logic [15:0] M1_LO   = 16'h1DCD;
    localparam logic [15:0] M1_HI   = 16'h1DE8;
    localparam logic [3:0]  S_A     = 4'hA;
    localparam logic [3:0]  S_B     = 4'h5;

    typedef struct {
        logic        pass_v;
        logic        fail_v;
        logic [15:0] c0;
        logic [15:0] c1;
        logic [31:0] cyc;
        logic [3:0]  st;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [37:0] io_in;
    logic        enable;
    logic        clear;
    logic [3:0]  state;
    logic        done, pass, fail;
    logic [15:0] cap0, cap1;
    logic [31:0] cycles;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [19:0] seq_w [SEQ_N];
    int          wp;
    int          checks = 0;
    int          errors = 0;
    logic        done_prev = 1'b0;
    bit          got;

    mprj_io_sequence_monitor #(.TIMEOUT_CYCLES(TMO)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .io_in    (io_in),
        .enable   (enable),
        .clear    (clear),
        .state    (state),
        .done     (done),
        .pass     (pass),
        .fail     (fail),
        .cap0     (cap0),
        .cap1     (cap1),
        .cycles   (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: compare on every rising edge of done.
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with state %0d want no completion", state);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_pass",   32'(pass),   32'(mon_e.pass_v));
                check("sb_fail",   32'(fail),   32'(mon_e.fail_v));
                check("sb_state",  32'(state),  32'(mon_e.st));
                check("sb_cap0",   32'(cap0),   32'(mon_e.c0));
                check("sb_cap1",   32'(cap1),   32'(mon_e.c1));
                check("sb_cycles", cycles,      mon_e.cyc);
            end
        end
        done_prev = done;
    end

    // Reference: the FSM at the m-th edge after arming sees the word driven m-3 edges earlier.
    function automatic exp_t model_run();
        exp_t        r;
        int          step;
        logic [31:0] cyc;
        logic [19:0] x;
        logic [15:0] cb;
        logic [3:0]  stt;
        r.pass_v = 1'b0; r.fail_v = 1'b0; r.c0 = '0; r.c1 = '0; r.cyc = '0; r.st = 4'd0;
        step = 0;
        cyc  = '0;
        for (int m = 1; m <= SEQ_N + 2; m++) begin
            x   = (m >= 3) ? seq_w[m-3] : 20'h0;
            cb  = x[15:0];
            stt = x[19:16];
            if (step == 5 && cb == W_END) begin
                r.pass_v = 1'b1; r.st = 4'd7; r.cyc = cyc;
                return r;
            end
            if (cyc == 32'(TMO - 1)) begin
                r.fail_v = 1'b1; r.st = 4'd8; r.cyc = cyc;
                return r;
            end
            case (step)
                0: if (cb == W_START) step = 1;
                1: if (stt == S_A) step = 2;
                2: if (stt == S_B) step = 3;
                3: if (cb >= M0_LO && cb <= M0_HI) begin r.c0 = cb; step = 4; end
                4: if (cb >= M1_LO && cb <= M1_HI) begin r.c1 = cb; step = 5; end
                default: ;
            endcase
            cyc = cyc + 32'd1;
        end
        return r;
    endfunction

    task automatic put(input logic [19:0] w, input int hold);
        for (int h = 0; h < hold; h++) begin
            if (wp < SEQ_N) begin
                seq_w[wp] = w;
                wp++;
            end
        end
    endtask

    function automatic logic [19:0] noise();
        return 20'($urandom);
    endfunction

    function automatic logic [19:0] step_word(input int s);
        logic [15:0] r = 16'($urandom);
        logic [3:0]  q = 4'($urandom);
        case (s)
            0:       return {q, W_START};
            1:       return {S_A, r};
            2:       return {S_B, r};
            3:       return {q, M0_LO + 16'($urandom_range(0, 35))};
            4:       return {q, M1_LO + 16'($urandom_range(0, 27))};
            default: return {q, W_END};
        endcase
    endfunction

    task automatic drive(input logic [19:0] w, input int n);
        io_in = {2'($urandom), w, 16'($urandom)};
        repeat (n) tick();
    endtask

    task automatic start_run();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        io_in = '0;
        repeat (3) tick();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        check("armed_state", 32'(state), 32'd1);
        check("armed_cycles", cycles, 32'd0);
    endtask

    task automatic run_scenario(input string name, output bit got_done);
        exp_t e;
        e = model_run();
        exp_q.push_back(e);
        start_run();
        got_done = 1'b0;
        for (int j = 0; j < SEQ_N && !got_done; j++) begin
            drive(seq_w[j], 1);
            got_done = done;
        end
        checks++;
        if (!got_done) begin
            errors++;
            $display("FAIL %s_done: got no done within %0d cycles want done", name, SEQ_N);
            e = exp_q.pop_front();
        end
        @(negedge clk);
        #1;
    endtask

    task automatic seq_basic(input logic [15:0] m0, input logic [15:0] m1, input bit with_end);
        wp = 0;
        put({4'h0, W_START}, 2);
        put({S_A, 16'h0}, 2);
        put({S_B, 16'h0}, 2);
        put({4'h0, m0}, 2);
        put({4'h0, m1}, 2);
        if (with_end) put({4'h0, W_END}, 2);
        while (wp < SEQ_N) put(20'h0, 1);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; clear = 1'b0; io_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state",  32'(state), 32'd0);
        check("rst_done",   32'(done),  32'd0);
        check("rst_pass",   32'(pass),  32'd0);
        check("rst_fail",   32'(fail),  32'd0);
        check("rst_cap0",   32'(cap0),  32'd0);
        check("rst_cap1",   32'(cap1),  32'd0);
        check("rst_cycles", cycles,     32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("idle_after_rst", 32'(state), 32'd0);

        // Nominal sequence, then stickiness of PASS.
        seq_basic(16'h1969, 16'h1DCE, 1'b1);
        run_scenario("nominal", got);
        check("nom_cap0",  32'(cap0),  32'h1969);
        check("nom_cap1",  32'(cap1),  32'h1DCE);
        check("nom_state", 32'(state), 32'd7);
        repeat (5) tick();
        check("nom_sticky_pass",  32'(pass),  32'd1);
        check("nom_sticky_state", 32'(state), 32'd7);

        // Inclusive window edges.
        seq_basic(16'h1968, 16'h1DE8, 1'b1);
        run_scenario("edges", got);
        check("edge_pass", 32'(pass), 32'd1);
        check("edge_cap0", 32'(cap0), 32'h1968);
        check("edge_cap1", 32'(cap1), 32'h1DE8);

        // Just below MID0 window held forever: timeout.
        wp = 0;
        put({4'h0, W_START}, 2);
        put({S_A, 16'h0}, 2);
        put({S_B, 16'h0}, 2);
        while (wp < SEQ_N) put({4'h0, 16'h1967}, 1);
        run_scenario("below_win", got);
        check("tmo_fail",   32'(fail),  32'd1);
        check("tmo_pass",   32'(pass),  32'd0);
        check("tmo_cycles", cycles,     32'd199);
        check("tmo_state",  32'(state), 32'd8);

        // Status B seen before A is ignored.
        wp = 0;
        put({4'h0, W_START}, 2);
        put({S_B, 16'h0}, 2);
        put({S_A, 16'h0}, 2);
        put({S_B, 16'h0}, 2);
        put({4'h0, 16'h1969}, 2);
        put({4'h0, 16'h1DCE}, 2);
        put({4'h0, W_END}, 2);
        while (wp < SEQ_N) put(20'h0, 1);
        run_scenario("ooo", got);
        check("ooo_pass", 32'(pass), 32'd1);

        // END reaches the comparator on the very edge the budget expires.
        wp = 0;
        put({4'h0, W_START}, 1);
        put({S_A, 16'h0}, 1);
        put({S_B, 16'h0}, 1);
        put({4'h0, 16'h1969}, 1);
        put({4'h0, 16'h1DCE}, 1);
        while (wp < TMO - 3) put(20'h0, 1);
        put({4'h0, W_END}, 1);
        while (wp < SEQ_N) put(20'h0, 1);
        run_scenario("tie", got);
        check("tie_pass",   32'(pass), 32'd1);
        check("tie_fail",   32'(fail), 32'd0);
        check("tie_cycles", cycles,    32'd199);

        // Two-stage synchroniser latency.
        start_run();
        tick();
        tick();
        io_in = {2'b00, 4'h0, W_START, 16'h0};
        tick();
        check("lat_k",  32'(state), 32'd1);
        tick();
        check("lat_k1", 32'(state), 32'd1);
        tick();
        check("lat_k2", 32'(state), 32'd2);

        // Clear from WAIT_M1.
        start_run();
        drive({4'h0, W_START}, 2);
        drive({S_A, 16'h0}, 2);
        drive({S_B, 16'h0}, 2);
        drive({4'h0, 16'h1969}, 2);
        for (int i = 0; i < 20 && state != 4'd5; i++) tick();
        check("clr_reach_m1", 32'(state), 32'd5);
        check("clr_cap0_pre", 32'(cap0),  32'h1969);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_state",  32'(state), 32'd0);
        check("clr_cycles", cycles,     32'd0);
        check("clr_cap0",   32'(cap0),  32'd0);
        check("clr_cap1",   32'(cap1),  32'd0);
        check("clr_done",   32'(done),  32'd0);
        repeat (4) tick();
        check("clr_stays_idle", 32'(state), 32'd0);

        // Asynchronous reset mid-clock in WAIT_END.
        start_run();
        drive({4'h0, W_START}, 2);
        drive({S_A, 16'h0}, 2);
        drive({S_B, 16'h0}, 2);
        drive({4'h0, 16'h1969}, 2);
        drive({4'h0, 16'h1DCE}, 2);
        for (int i = 0; i < 20 && state != 4'd6; i++) tick();
        check("rst_reach_end", 32'(state), 32'd6);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_state",  32'(state), 32'd0);
        check("arst_cycles", cycles,     32'd0);
        check("arst_cap0",   32'(cap0),  32'd0);
        check("arst_cap1",   32'(cap1),  32'd0);
        check("arst_done",   32'(done),  32'd0);
        io_in = {2'b00, 4'h0, W_END, 16'h0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) tick();
        check("arst_no_restart", 32'(state), 32'd0);
        check("arst_no_pass",    32'(pass),  32'd0);

        // Randomised sequences, some with a step missing.
        for (int n = 0; n < 16; n++) begin
            int skip;
            skip = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 5)) : -1;
            wp = 0;
            for (int s = 0; s < 6; s++) begin
                repeat ($urandom_range(0, 2)) put(noise(), int'($urandom_range(1, 3)));
                if (s != skip) put(step_word(s), int'($urandom_range(1, 3)));
            end
            while (wp < SEQ_N) put(noise(), 1);
            run_scenario("rnd", got);
        end

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500000 want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mprj_io_sequence_monitor.md
MPRJ_IO_SEQUENCE_MONITOR -- requirements
Module: mprj_io_sequence_monitor

Interface
REQ-001 SHALL have parameter START_WORD, default 16'hAB40, checkbits value that arms the sequence.
REQ-002 SHALL have parameter END_WORD, default 16'hAB51, checkbits value that completes the sequence.
REQ-003 SHALL have parameters STATUS_A (default 4'hA) and STATUS_B (default 4'h5), the required status values, in order.
REQ-004 SHALL have parameters MID0_LO/MID0_HI (defaults 16'h1968/16'h198B) and MID1_LO/MID1_HI (defaults 16'h1DCD/16'h1DE8), inclusive acceptance windows.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 100000, the cycle budget from arming to completion.
REQ-006 wb_clk_i  input  1  single clock; all flops on rising edge.
REQ-007 wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-008 io_in  input  38  user GPIO pad inputs; checkbits = io_in[31:16], status = io_in[35:32]; asynchronous to wb_clk_i.
REQ-009 enable  input  1  start monitoring; sampled only in IDLE.
REQ-010 clear  input  1  synchronous restart to IDLE.
REQ-011 state  output  4  current FSM state encoding.
REQ-012 done  output  1  high in PASS or FAIL.
REQ-013 pass  output  1  high in PASS only.
REQ-014 fail  output  1  high in FAIL only.
REQ-015 cap0, cap1  output  16 each  checkbits captured at the MID0/MID1 steps.
REQ-016 cycles  output  32  cycles elapsed since leaving IDLE; frozen in PASS/FAIL.

Function
REQ-017 io_in[35:16] SHALL pass through a 2-flop synchroniser; the FSM SHALL compare only the second-stage value (sync2).
REQ-018 Latency: a value stable on io_in before edge k SHALL affect state/outputs after edge k+2.
REQ-019 States: IDLE=0, WAIT_START=1, WAIT_SA=2, WAIT_SB=3, WAIT_M0=4, WAIT_M1=5, WAIT_END=6, PASS=7, FAIL=8.
REQ-020 IDLE -> WAIT_START when enable=1; cycles cleared to 0 on that edge.
REQ-021 WAIT_START -> WAIT_SA when sync2 checkbits == START_WORD.
REQ-022 WAIT_SA -> WAIT_SB when sync2 status == STATUS_A; WAIT_SB -> WAIT_M0 when sync2 status == STATUS_B.
REQ-023 WAIT_M0 -> WAIT_M1 when MID0_LO <= checkbits <= MID0_HI, loading cap0 with that value; WAIT_M1 -> WAIT_END likewise with the MID1 window, loading cap1.
REQ-024 WAIT_END -> PASS when checkbits == END_WORD.
REQ-025 Non-matching values SHALL be ignored (no failure on out-of-order data); only timeout causes FAIL.
REQ-026 In states 1-6, cycles SHALL increment by 1 per edge, saturating at 2^32-1.
REQ-027 When cycles == TIMEOUT_CYCLES-1 in states 1-6, the FSM SHALL enter FAIL on the next edge.
REQ-028 If the END_WORD match and the timeout fall on the same edge, PASS SHALL win.
REQ-029 PASS and FAIL SHALL be sticky until clear or reset.
REQ-030 clear=1 SHALL force IDLE from any state, zero cycles/cap0/cap1; clear SHALL take priority over enable and all matches.
REQ-031 enable deasserted outside IDLE SHALL be ignored.
REQ-032 done/pass/fail SHALL be registered, decoded from the state register (no combinational path from io_in).

Reset
REQ-033 wb_rst_i=1 SHALL asynchronously set state=IDLE, done=pass=fail=0, cap0=cap1=0, cycles=0, and both synchroniser stages to 0.
REQ-034 Reset asserted mid-sequence SHALL abandon it; after release, monitoring SHALL restart only on a new enable.

Verification
REQ-035 Nominal: enable; drive AB40, status A, status 5, checkbits 1969, then 1DCE, then AB51 -> pass=1, cap0=16'h1969, cap1=16'h1DCE, state=7.
REQ-036 Window edges: MID values 1968 and 1DE8 -> pass; MID value 1967 held with TIMEOUT_CYCLES=200 -> fail=1 at cycles=199.
REQ-037 Out-of-order: status 5 before status A, then A, then 5 -> WAIT_SB reached only after A; sequence still passes.
REQ-038 Tie: END_WORD reaches sync2 on the same edge that timeout triggers -> pass=1, fail=0.
REQ-039 Latency: toggle checkbits to AB40 just before edge k in WAIT_START -> state=2 after edge k+2, not earlier.
REQ-040 Clear/reset: pulse clear in WAIT_M1, then assert wb_rst_i asynchronously mid-clock in WAIT_END -> IDLE, all outputs 0, no spurious pass.
